// File: rtl/alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arb
// Description : Round-robin sharing of one combinational ALU between two
//               valid/ready requesters; operands and result are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arb #(
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_valid_0,
    input  logic             req_valid_1,
    output logic             req_ready_0,
    output logic             req_ready_1,
    input  logic [WIDTH-1:0] req_a_0,
    input  logic [WIDTH-1:0] req_a_1,
    input  logic [WIDTH-1:0] req_b_0,
    input  logic [WIDTH-1:0] req_b_1,
    input  logic [3:0]       req_op_0,
    input  logic [3:0]       req_op_1,
    input  logic [31:0]      req_inst_0,
    input  logic [31:0]      req_inst_1,
    output logic             rsp_valid_0,
    output logic             rsp_valid_1,
    input  logic             rsp_ready_0,
    input  logic             rsp_ready_1,
    output logic [WIDTH-1:0] rsp_res,
    output logic             rsp_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    output logic [31:0]      alu_inst,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_zero,
    output logic             busy
);

    localparam int c_cnt_w = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [c_cnt_w-1:0] c_lat_m1 = c_cnt_w'(ALU_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_owner;
    logic               r_prio;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_alu_a;
    logic [WIDTH-1:0]   r_alu_b;
    logic [3:0]         r_alu_op;
    logic [31:0]        r_alu_inst;
    logic [WIDTH-1:0]   r_rsp_res;
    logic               r_rsp_zero;

    logic w_grant;
    logic w_accept;
    logic w_rsp_ack;

    // Grant index: prio breaks ties, otherwise whichever requester is valid.
    always_comb begin
        w_grant = 1'b0;
        if (req_valid_0 && req_valid_1) begin
            w_grant = r_prio;
        end else if (req_valid_1) begin
            w_grant = 1'b1;
        end
    end

    assign w_accept  = (r_state == S_IDLE) && (req_valid_0 || req_valid_1);
    assign w_rsp_ack = r_owner ? rsp_ready_1 : rsp_ready_0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_EXEC;
            S_EXEC:  if (r_cnt == '0) w_state_nxt = S_RESP;
            S_RESP:  if (w_rsp_ack) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_owner    <= 1'b0;
            r_prio     <= 1'b0;
            r_cnt      <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_alu_inst <= '0;
            r_rsp_res  <= '0;
            r_rsp_zero <= 1'b0;
        end else begin
            if (w_accept) begin
                r_owner    <= w_grant;
                r_alu_a    <= w_grant ? req_a_1    : req_a_0;
                r_alu_b    <= w_grant ? req_b_1    : req_b_0;
                r_alu_op   <= w_grant ? req_op_1   : req_op_0;
                r_alu_inst <= w_grant ? req_inst_1 : req_inst_0;
                r_cnt      <= c_lat_m1;
            end
            if (r_state == S_EXEC) begin
                if (r_cnt == '0) begin
                    r_rsp_res  <= alu_res;
                    r_rsp_zero <= alu_zero;
                end else begin
                    r_cnt <= r_cnt - c_cnt_w'(1);
                end
            end
            if ((r_state == S_RESP) && w_rsp_ack) begin
                r_prio <= ~r_owner;
            end
        end
    end

    assign req_ready_0 = w_accept && !w_grant;
    assign req_ready_1 = w_accept &&  w_grant;
    assign rsp_valid_0 = (r_state == S_RESP) && !r_owner;
    assign rsp_valid_1 = (r_state == S_RESP) &&  r_owner;
    assign rsp_res     = r_rsp_res;
    assign rsp_zero    = r_rsp_zero;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_op      = r_alu_op;
    assign alu_inst    = r_alu_inst;
    assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire
